mips_multicycle_control: RTL and testbench

- Multicycle MIPS control unit; generational successor to the single-cycle clocked decoder.
- Sequences every instruction through an FSM and drives datapath mux/enable strobes per state.
- Waits on a variable-latency memory handshake; keeps a retired-instruction count and a halt status.
- Sits between the instruction register (opcode/funct), the ALU zero flag and the shared instruction/data memory.

---
 rtl/mips_ctrl_pkg.sv | 16 +
 rtl/mips_multicycle_control_if.sv | 6 +
 rtl/mips_instr_class.sv | 23 ++
 rtl/mips_multicycle_control.sv | 128 ++++++++++++
 tb/tb_mips_multicycle_control.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, ALU codes, FSM states and datapath mux encodings
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05;
   localparam logic [5:0] OP_XORI = 6'h0e, OP_LW = 6'h23, OP_SW = 6'h2b;
   localparam logic [5:0] FN_NOOP = 6'h00, FN_JR = 6'h08, FN_SYSCALL = 6'h0c;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_XOR = 6'h26, FN_SLT = 6'h2a;
   localparam logic [5:0] ALU_ADD = FN_ADD, ALU_SUB = FN_SUB, ALU_XOR = FN_XOR;
   typedef enum logic [3:0] {S_START, S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WB, S_JUMP, S_HALT} state_t;
   localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
   localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
   localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
   localparam logic [1:0] B_RT = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_IMMSH = 2'd3;
   typedef struct packed {
      logic rtype, lw, sw, bne, xori, j, jal, jr, noop, syscall, illegal;
   } iclass_t;
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: shared instruction/data memory handshake
interface mips_multicycle_control_if;
   logic mem_read, mem_write, i_or_d, mem_ready;
   modport master(output mem_read, mem_write, i_or_d, input mem_ready);
   modport slave(input mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/mips_instr_class.sv
// mips_instr_class: opcode/funct to one-hot instruction class
module mips_instr_class import mips_ctrl_pkg::*; (
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    cls
);
   logic r;
   always_comb begin
      r = opcode == OP_RTYPE;
      cls = '0;
      cls.rtype = r && (funct inside {FN_ADD, FN_SUB, FN_SLT});
      cls.jr = r && funct == FN_JR;
      cls.syscall = r && funct == FN_SYSCALL;
      cls.noop = r && funct == FN_NOOP;
      cls.lw = opcode == OP_LW;
      cls.sw = opcode == OP_SW;
      cls.bne = opcode == OP_BNE;
      cls.xori = opcode == OP_XORI;
      cls.j = opcode == OP_J;
      cls.jal = opcode == OP_JAL;
      cls.illegal = ~|cls;
   end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with memory handshake and retire counter.
// CTRL_ILLEGAL_TRAP_EN: unlisted encodings halt the core and raise illegal_op instead of retiring.
module mips_multicycle_control import mips_ctrl_pkg::*; #(
   parameter int ALUOP_W = 6,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               alu_zero,
   mips_multicycle_control_if.master mem,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wb_sel,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               imm_zext,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               halted,
   output logic               retired,
   output logic [CNT_W-1:0]   retired_cnt,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [3:0]         state_dbg
);
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   state_t state, nxt;
   logic [5:0] op_q, fn_q, aop;
   logic mr, mw, iod;
   iclass_t cls;
   // DECODE classifies the live IR; later states use the copy latched in DECODE
   mips_instr_class u_cls (
      .opcode(state == S_DECODE ? opcode : op_q),
      .funct(state == S_DECODE ? funct : fn_q),
      .cls(cls)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_START;
         op_q <= '0;
         fn_q <= '0;
         retired_cnt <= '0;
      end else begin
         state <= nxt;
         if (state == S_DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
         end
         retired_cnt <= retired_cnt + CNT_W'(retired);
      end
   always_comb begin
      nxt = state;
      {mr, mw, iod, ir_write, pc_write, reg_write, alu_src_a, imm_zext, halted, retired} = '0;
      {pc_src, reg_dst, wb_sel, alu_src_b} = '0;
      aop = '0;
      case (state)
         S_START: nxt = S_FETCH;
         S_FETCH: begin
            mr = 1'b1;
            alu_src_b = B_FOUR;
            aop = ALU_ADD;
            ir_write = mem.mem_ready;
            pc_write = mem.mem_ready;
            nxt = mem.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = B_IMMSH;
            aop = ALU_ADD;
            nxt = cls.j || cls.jal || cls.jr ? S_JUMP :
                  cls.syscall || (TRAP && cls.illegal) ? S_HALT :
                  cls.noop || cls.illegal ? S_FETCH : S_EXEC;
            retired = cls.noop || cls.syscall || (!TRAP && cls.illegal);
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = cls.rtype || cls.bne ? B_RT : B_IMM;
            imm_zext = cls.xori;
            aop = cls.rtype ? fn_q : cls.xori ? ALU_XOR : cls.bne ? ALU_SUB : ALU_ADD;
            pc_src = cls.bne ? PC_ALUOUT : PC_ALU;
            pc_write = cls.bne && !alu_zero;
            retired = cls.bne;
            nxt = cls.bne ? S_FETCH : cls.lw || cls.sw ? S_MEMACC : S_WB;
         end
         S_MEMACC: begin
            iod = 1'b1;
            mr = cls.lw;
            mw = cls.sw;
            retired = mem.mem_ready && cls.sw;
            nxt = !mem.mem_ready ? S_MEMACC : cls.lw ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst = cls.rtype ? RD_RD : RD_RT;
            wb_sel = cls.lw ? WB_MDR : WB_ALUOUT;
            retired = 1'b1;
            nxt = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src = cls.jr ? PC_RS : PC_JUMP;
            reg_write = cls.jal;
            reg_dst = cls.jal ? RD_RA : RD_RT;
            wb_sel = cls.jal ? WB_PC : WB_ALUOUT;
            retired = 1'b1;
            nxt = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: nxt = S_START;
      endcase
   end
   assign mem.mem_read = mr;
   assign mem.mem_write = mw;
   assign mem.i_or_d = iod;
   assign alu_op = ALUOP_W'(aop);
   assign state_dbg = state;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal_op = state == S_HALT && cls.illegal;
`endif
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random instruction traces checked against a per-instruction cycle model
module tb_mips_multicycle_control;
   typedef struct packed {
      logic [3:0] st;
      logic mr, mw, iod, irw, pcw;
      logic [1:0] pcs;
      logic rw;
      logic [1:0] rd, wb;
      logic asa;
      logic [1:0] asb;
      logic zx;
      logic [5:0] aop;
      logic hlt, ret;
   } cyc_t;
   typedef struct {
      logic [5:0] op, fn;
      logic rdy, z;
      cyc_t e;
   } ent_t;
   localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_XORI = 3, K_LW = 4, K_SW = 5, K_BNE = 6;
   localparam int K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10, K_ILL = 11, K_SYS = 12;
   string nm[13] = '{"add", "sub", "slt", "xori", "lw", "sw", "bne", "j", "jal", "jr", "nop", "ill", "sys"};
   logic clk = 1'b0, rst_n = 1'b0;
   logic [5:0] opcode, funct, alu_op;
   logic alu_zero, ir_write, pc_write, reg_write, alu_src_a, imm_zext, halted, retired;
   logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b;
   logic [31:0] retired_cnt;
   logic [3:0] state_dbg;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_op;
`endif
   int n = 0, errs = 0;
   int unsigned cnt = 0;
   ent_t q[$];
   mips_multicycle_control_if mem_if();
   always #5 clk = ~clk;
   mips_multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .mem(mem_if),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_zext(imm_zext), .alu_op(alu_op), .halted(halted), .retired(retired),
      .retired_cnt(retired_cnt),
`ifdef CTRL_ILLEGAL_TRAP_EN
      .illegal_op(illegal_op),
`endif
      .state_dbg(state_dbg)
   );
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic cyc_t obs();
      cyc_t c;
      c = {state_dbg, mem_if.mem_read, mem_if.mem_write, mem_if.i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, wb_sel, alu_src_a, alu_src_b, imm_zext, alu_op, halted, retired};
      return c;
   endfunction
   function automatic cyc_t base(int st);
      cyc_t c = '0;
      c.st = 4'(st);
      return c;
   endfunction
   function automatic logic [5:0] r6();
      return 6'($urandom);
   endfunction
   function automatic logic r1();
      return 1'($urandom);
   endfunction
   task automatic add(cyc_t c, logic [5:0] op, logic [5:0] fn, logic rdy, logic z);
      ent_t e;
      e.op = op;
      e.fn = fn;
      e.rdy = rdy;
      e.z = z;
      e.e = c;
      q.push_back(e);
   endtask
   // one instruction as a cycle trace: lf/lm are wait cycles before mem_ready in fetch/memory access
   task automatic gen(int k, int lf, int lm, logic z);
      cyc_t c;
      logic [5:0] op, fn;
      logic [5:0] ill_op[4] = '{6'h01, 6'h08, 6'h0f, 6'h3f};
      logic [5:0] ill_fn[4] = '{6'h21, 6'h25, 6'h03, 6'h2b};
      fn = r6();
      case (k)
         K_ADD: begin op = 6'h00; fn = 6'h20; end
         K_SUB: begin op = 6'h00; fn = 6'h22; end
         K_SLT: begin op = 6'h00; fn = 6'h2a; end
         K_XORI: op = 6'h0e;
         K_LW: op = 6'h23;
         K_SW: op = 6'h2b;
         K_BNE: op = 6'h05;
         K_J: op = 6'h02;
         K_JAL: op = 6'h03;
         K_JR: begin op = 6'h00; fn = 6'h08; end
         K_NOP: begin op = 6'h00; fn = 6'h00; end
         K_SYS: begin op = 6'h00; fn = 6'h0c; end
         default: if (r1()) begin op = 6'h00; fn = ill_fn[$urandom % 4]; end
                  else op = ill_op[$urandom % 4];
      endcase
      for (int i = 0; i <= lf; i++) begin
         c = base(1); c.mr = 1; c.asb = 1; c.aop = 6'h20; c.irw = i == lf; c.pcw = i == lf;
         add(c, r6(), r6(), i == lf, r1());
      end
      c = base(2); c.asb = 3; c.aop = 6'h20; c.ret = k inside {K_NOP, K_ILL, K_SYS};
      add(c, op, fn, r1(), r1());
      if (k <= K_BNE) begin
         c = base(3); c.asa = 1; c.asb = k inside {K_XORI, K_LW, K_SW} ? 2'd2 : 2'd0; c.zx = k == K_XORI;
         c.aop = k == K_XORI ? 6'h26 : k == K_BNE ? 6'h22 : k inside {K_LW, K_SW} ? 6'h20 : fn;
         if (k == K_BNE) begin c.pcs = 1; c.pcw = !z; c.ret = 1; end
         add(c, r6(), r6(), r1(), z);
      end
      if (k inside {K_LW, K_SW})
         for (int i = 0; i <= lm; i++) begin
            c = base(4); c.iod = 1; c.mr = k == K_LW; c.mw = k == K_SW; c.ret = i == lm && k == K_SW;
            add(c, r6(), r6(), i == lm, r1());
         end
      if (k <= K_LW && k != K_SW || k == K_LW) begin
         c = base(5); c.rw = 1; c.rd = k <= K_SLT ? 2'd1 : 2'd0; c.wb = k == K_LW ? 2'd1 : 2'd0; c.ret = 1;
         add(c, r6(), r6(), r1(), r1());
      end
      if (k inside {K_J, K_JAL, K_JR}) begin
         c = base(6); c.pcw = 1; c.pcs = k == K_JR ? 2'd3 : 2'd2; c.ret = 1;
         if (k == K_JAL) begin c.rw = 1; c.rd = 2; c.wb = 2; end
         add(c, r6(), r6(), r1(), r1());
      end
      if (k == K_SYS)
         for (int i = 0; i < 10; i++) begin
            c = base(7); c.hlt = 1;
            add(c, r6(), r6(), 1'b1, r1());
         end
   endtask
   task automatic run(string tag);
      while (q.size() > 0) begin
         ent_t e = q.pop_front();
         opcode = e.op;
         funct = e.fn;
         mem_if.mem_ready = e.rdy;
         alu_zero = e.z;
         @(negedge clk);
         chk({tag, "/out"}, 64'(obs()), 64'(e.e));
         chk({tag, "/cnt"}, 64'(retired_cnt), 64'(cnt));
         if (e.e.ret) cnt++;
         @(posedge clk);
         #1;
      end
   endtask
   task automatic rand_instrs(int num);
      int k;
      for (int i = 0; i < num; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         k = $urandom % 11;
`else
         k = $urandom % 12;
`endif
         gen(k, $urandom % 3, $urandom % 4, r1());
         run(nm[k]);
      end
   endtask
   initial begin
      opcode = 0; funct = 0; alu_zero = 0; mem_if.mem_ready = 1;
      #2;
      chk("reset_out", 64'(obs()), 64'(base(0)));
      chk("reset_cnt", 64'(retired_cnt), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      add(base(0), r6(), r6(), 1'b1, r1());
      gen(K_ADD, 0, 0, 1'b0);
      gen(K_LW, 0, 3, 1'b0);
      gen(K_BNE, 0, 0, 1'b0);
      gen(K_BNE, 0, 0, 1'b1);
      gen(K_JAL, 0, 0, 1'b0);
      run("directed");
      rand_instrs(80);
      gen(K_SW, 0, 3, 1'b0);
      while (q.size() > 4) void'(q.pop_back());
      run("sw_rst");
      chk("sw_hold", 64'(mem_if.mem_write), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mw", 64'(mem_if.mem_write), 64'd0);
      chk("rst_out", 64'(obs()), 64'(base(0)));
      chk("rst_cnt", 64'(retired_cnt), 64'd0);
      cnt = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      add(base(0), r6(), r6(), r1(), r1());
      run("restart");
      rand_instrs(40);
      gen(K_SYS, 1, 0, 1'b0);
      run("sys");
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("illegal_op", 64'(illegal_op), 64'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
